// File: rtl/axi_lite_regfile_pkg.sv
// Shared response codes, write-channel debug state and byte/index helpers for the AXI4-Lite register file.
package axi_lite_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write-channel progress, exposed so checkers can observe it.
  typedef struct packed {
    logic aw_held;
    logic w_held;
    logic b_pending;
  } wr_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int k = 0; k < 4; k++) begin
      if (wstrb[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

  function automatic logic idx_legal(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AW/W capture with independent hold flags and B-channel generation.
// Optional AXIL_REGFILE_PROT_EN: unprivileged writes (awprot[0]=0) are rejected with SLVERR.
module axi_lite_wr_ctrl
  import axi_lite_regfile_pkg::*;
#(
  parameter int                    ADDR_W   = 5,
  parameter int                    NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              commit,
  output logic [ADDR_W-3:0] idx,
  output logic [31:0]       data,
  output logic [3:0]        strb,
  output wr_state_t         state
);

  // Handshake rule: a beat transfers on a rising edge where valid && ready;
  // valid must then hold its payload until that edge, ready may toggle freely.
  localparam int IDX_W = ADDR_W - 2;

  logic             aw_held, w_held, prot_q;
  logic [IDX_W-1:0] idx_q;
  logic             both_held, is_ro, err;

  assign awready   = en && !aw_held && !bvalid;
  assign wready    = en && !w_held && !bvalid;
  assign both_held = aw_held && w_held;

  always_comb begin
    is_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_q == IDX_W'(i)) is_ro = RO_MASK[i];
    end
    err = !idx_legal(32'(idx_q), NUM_REGS) || is_ro;
`ifdef AXIL_REGFILE_PROT_EN
    err = err || !prot_q;
`endif
  end

  assign commit = both_held && !err;
  assign idx    = idx_q;
  assign state  = '{aw_held: aw_held, w_held: w_held, b_pending: bvalid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      prot_q  <= 1'b0;
      idx_q   <= '0;
      data    <= '0;
      strb    <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        idx_q   <= awaddr[ADDR_W-1:2];
        prot_q  <= awprot[0];
      end
      if (wvalid && wready) begin
        w_held <= 1'b1;
        data   <= wdata;
        strb   <= wstrb;
      end
      // Handshakes are blocked while both are held or bvalid is up, so these never collide.
      if (both_held) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{awaddr[1:0], awprot[2:1], prot_q};

endmodule

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI4-Lite register file: RW registers with byte strobes, RO slots mirroring regs_i.
// Optional AXIL_REGFILE_PROT_EN: unprivileged (prot[0]=0) accesses get SLVERR.
module axi_lite_regfile
  import axi_lite_regfile_pkg::*;
#(
  parameter int                      C_S_AXI_DATA_WIDTH = 32,
  parameter int                      C_S_AXI_ADDR_WIDTH = 5,
  parameter int                      C_NUM_REGS         = 8,
  parameter logic [C_NUM_REGS-1:0]   C_RO_MASK          = 8'h02
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_NUM_REGS*32-1:0]        regs_o,
  input  logic [C_NUM_REGS*32-1:0]        regs_i,
  output logic [C_NUM_REGS-1:0]           wr_pulse_o
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  logic             ready_en;
  logic             wr_commit;
  logic [IDX_W-1:0] wr_idx, ar_idx;
  logic [31:0]      wr_data, rd_val;
  logic [3:0]       wr_strb;
  logic             rd_err;
  wr_state_t        wr_state;
  logic [31:0]      regs [C_NUM_REGS];

  // Keeps every ready low until the first edge after reset release.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  axi_lite_wr_ctrl #(
    .ADDR_W   (C_S_AXI_ADDR_WIDTH),
    .NUM_REGS (C_NUM_REGS),
    .RO_MASK  (C_RO_MASK)
  ) u_wr_ctrl (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .en      (ready_en),
    .awaddr  (s_axi_awaddr),
    .awprot  (s_axi_awprot),
    .awvalid (s_axi_awvalid),
    .awready (s_axi_awready),
    .wdata   (s_axi_wdata),
    .wstrb   (s_axi_wstrb),
    .wvalid  (s_axi_wvalid),
    .wready  (s_axi_wready),
    .bresp   (s_axi_bresp),
    .bvalid  (s_axi_bvalid),
    .bready  (s_axi_bready),
    .commit  (wr_commit),
    .idx     (wr_idx),
    .data    (wr_data),
    .strb    (wr_strb),
    .state   (wr_state)
  );

  // RO slots are never committed, so their storage stays at zero.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) regs[i] <= strb_merge(regs[i], wr_data, wr_strb);
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_pulse_o <= '0;
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) wr_pulse_o[i] <= wr_commit && (wr_idx == IDX_W'(i));
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < C_NUM_REGS; i++) regs_o[i*32 +: 32] = C_RO_MASK[i] ? 32'h0 : regs[i];
  end

  assign ar_idx        = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign s_axi_arready = ready_en && !s_axi_rvalid;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_val = C_RO_MASK[i] ? regs_i[i*32 +: 32] : regs[i];
    end
    rd_err = !idx_legal(32'(ar_idx), C_NUM_REGS);
`ifdef AXIL_REGFILE_PROT_EN
    rd_err = rd_err || !s_axi_arprot[0];
`endif
  end

  // Sampling on the AR edge sees the pre-commit register value.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_err ? 32'h0 : rd_val;
      s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_araddr[1:0], s_axi_arprot, regs_i, wr_state};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (6 registers, register 1 read-only) with a B/R response scoreboard.
module tb_axi_lite_regfile;

  localparam int NR = 6;
  localparam int AW = 5;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    awaddr = '0, araddr = '0;
  logic [2:0]       awprot = 3'b001, arprot = 3'b001;
  logic             awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic             bready = 1'b1, rready = 1'b1;
  logic [31:0]      wdata = '0;
  logic [3:0]       wstrb = '0;
  logic [NR*32-1:0] regs_i = '0;
  logic             awready, wready, bvalid, arready, rvalid;
  logic [1:0]       bresp, rresp;
  logic [31:0]      rdata;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0]    wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [31:0] model [NR];

  axi_lite_regfile #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (AW),
    .C_NUM_REGS         (NR),
    .C_RO_MASK          (6'h02)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .regs_o        (regs_o),
    .regs_i        (regs_i),
    .wr_pulse_o    (wr_pulse)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual=timeout expected=handshake", name);
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  // Scoreboard monitors: compare when a response is presented and accepted.
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (exp_b_q.size() == 0) fail("b_unexpected");
      else check("bresp", bresp, exp_b_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (exp_r_q.size() == 0) fail("r_unexpected");
      else check("rresp_rdata", {rresp, rdata}, exp_r_q.pop_front());
    end
  end

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input logic [1:0] exp_resp,
                          input logic [NR-1:0] exp_pulse, input bit hold);
    bit aw_done, w_done, aw_fire, w_fire;
    int aw_cyc;
    aw_done = 0; w_done = 0; aw_cyc = -1;
    exp_b_q.push_back(exp_resp);
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb;
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      awvalid = !aw_done && (cyc >= aw_delay);
      wvalid  = !w_done && (cyc >= w_delay);
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) begin aw_done = 1; aw_cyc = cyc; end
      if (w_fire) w_done = 1;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin
      fail("wr_handshake");
      return;
    end
    check("aw_accept_cycle", aw_cyc, aw_delay);
    @(negedge clk);
    check("b_not_early", bvalid, 1'b0);
    @(negedge clk);
    check("b_latency", bvalid, 1'b1);
    check("wr_pulse", wr_pulse, exp_pulse);
    @(negedge clk);
    check("wr_pulse_single", wr_pulse, '0);
    check("b_after_ready", bvalid, hold);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input bit hold);
    bit fired, ar_fire;
    fired = 0;
    exp_r_q.push_back({exp_resp, exp_data});
    @(posedge clk); #1;
    araddr = addr;
    for (int cyc = 0; cyc < 40 && !fired; cyc++) begin
      arvalid = 1;
      @(negedge clk);
      ar_fire = arready;
      @(posedge clk); #1;
      if (ar_fire) fired = 1;
    end
    arvalid = 0;
    if (!fired) begin
      fail("rd_handshake");
      return;
    end
    @(negedge clk);
    check("r_latency", rvalid, 1'b1);
    @(negedge clk);
    check("r_after_ready", rvalid, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {awready, wready, arready, bvalid, rvalid, wr_pulse}, '0);
    check("rst_regs", regs_o, '0);
    @(posedge clk); #3;
    rst_n = 1;
    @(negedge clk);
    check("ready_before_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    check("ready_after_edge", {awready, wready, arready}, 3'b111);

    // Same-cycle AW/W
    do_write(5'h00, 32'h12345678, 4'hF, 0, 0, OKAY, 6'h01, 0);
    model[0] = 32'h12345678;
    check("regs_o_w0", regs_o, model_flat());
    do_read(5'h00, 32'h12345678, OKAY, 0);

    // W three cycles ahead of AW
    do_write(5'h08, 32'hAA55AA55, 4'hF, 3, 0, OKAY, 6'h04, 0);
    model[2] = 32'hAA55AA55;
    do_read(5'h08, 32'hAA55AA55, OKAY, 0);

    // Partial strobe merge
    do_write(5'h08, 32'h11223344, 4'b0101, 0, 0, OKAY, 6'h04, 0);
    model[2] = 32'hAA22AA44;
    check("regs_o_merge", regs_o, model_flat());
    do_read(5'h08, 32'hAA22AA44, OKAY, 0);

    // Read-only slot
    regs_i[63:32] = 32'hDEADBEEF;
    do_write(5'h04, 32'h0BADC0DE, 4'hF, 0, 0, SLVERR, 6'h00, 0);
    check("regs_o_ro_zero", regs_o, model_flat());
    regs_i[63:32] = 32'h00C0FFEE;
    do_read(5'h04, 32'h00C0FFEE, OKAY, 0);

    // Out-of-range index
    do_read(5'h18, 32'h0, SLVERR, 0);
    do_write(5'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, SLVERR, 6'h00, 0);
    check("regs_o_oor", regs_o, model_flat());

    // Byte-offset bits ignored, empty strobe
    do_write(5'h03, 32'hFF000000, 4'b1000, 1, 0, OKAY, 6'h01, 0);
    model[0] = 32'hFF345678;
    do_read(5'h01, 32'hFF345678, OKAY, 0);
    do_write(5'h0C, 32'h5A5A5A5A, 4'b0000, 0, 2, OKAY, 6'h08, 0);
    do_read(5'h0C, 32'h0, OKAY, 0);
    check("regs_o_nostrb", regs_o, model_flat());

    // Backpressure hold, then reset mid-hold
    bready = 0; rready = 0;
    do_write(5'h00, 32'hCAFEF00D, 4'hF, 0, 0, OKAY, 6'h01, 1);
    do_read(5'h00, 32'hCAFEF00D, OKAY, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_stable", {bvalid, rvalid, bresp, rresp, rdata, awready, wready, arready},
            {1'b1, 1'b1, OKAY, OKAY, 32'hCAFEF00D, 3'b000});
    end
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("async_drop", {bvalid, rvalid, wr_pulse}, '0);
    check("async_regs", regs_o, '0);
    exp_b_q.delete();
    exp_r_q.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    bready = 1; rready = 1;
    @(posedge clk); #3;
    rst_n = 1;
    @(negedge clk);
    check("rerst_ready_low", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    check("rerst_ready_high", {awready, wready, arready}, 3'b111);
    do_read(5'h00, 32'h0, OKAY, 0);

    repeat (3) @(posedge clk);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file. It is the generalised successor of the fixed control/status/scratch slave.
- Provides C_NUM_REGS 32-bit-aligned registers.
- Each register is RW or RO, selected per bit of C_RO_MASK. RO registers mirror the live inputs.
- Supports byte strobes and independent AW/W acceptance.
- Returns SLVERR for illegal accesses.
- Sits between the PS interconnect and accelerator control/status logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported, 4 strobe bits
C_S_AXI_ADDR_WIDTH, 5, byte address width; register index = addr[ADDR_W-1:2]
C_NUM_REGS, 8, implemented registers; must be <= 2**(ADDR_W-2)
C_RO_MASK, 8'h02, bit i = 1 means register i is read-only, sourced from regs_i

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset, asynchronous, active-low
s_axi_awaddr/awprot/awvalid  in  ADDR_W/3/1  write address
s_axi_awready  out  1
s_axi_wdata/wstrb/wvalid  in  32/4/1  write data
s_axi_wready  out  1
s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1
s_axi_araddr/arprot/arvalid  in  ADDR_W/3/1  read address
s_axi_arready  out  1
s_axi_rdata  out  32;  s_axi_rresp  out  2;  s_axi_rvalid  out  1;  s_axi_rready  in  1
regs_o  out  NUM_REGS*32  flattened RW register contents; RO slots drive 0
regs_i  in  NUM_REGS*32  flattened status inputs; only RO slots are used
wr_pulse_o  out  NUM_REGS  one-cycle strobe per successfully written register

Behaviour:
- Reset (async assert): all outputs, RW registers, captured address/data and pending flags go to 0. Ready signals rise on the first clock edge after deassertion.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W may arrive in either order or in the same cycle. Each is latched on its handshake.
  - Commit occurs on the edge after both are held. At that edge: bvalid=1, wr_pulse_o[idx]=1 for that single cycle (OKAY only), held flags clear.
  - Latency: bvalid 1 cycle after the later handshake.
  - Byte merge: reg[8k+7:8k] <= wdata[8k+7:8k] when wstrb[k]=1; unstrobed bytes keep their value. wstrb=0 gives OKAY, no change, pulse still asserted.
  - bresp = SLVERR (2'b10), with no change and no pulse, when idx >= NUM_REGS or C_RO_MASK[idx]. Otherwise OKAY (2'b00).
  - bvalid holds until bready. No new AW/W is accepted while bvalid is high.
- Read channel:
  - arready = !rvalid (one outstanding read).
  - On the AR handshake edge: rdata <= RW reg, or regs_i slot if RO, or 0 if out of range; rvalid <= 1.
  - Latency: rvalid 1 cycle after the handshake. rdata/rresp stay stable until rready.
  - rresp = SLVERR for out-of-range index, otherwise OKAY. A read of an RO register is legal.
- Simultaneous read and write to the same register: the AR handshake edge samples the pre-commit value. A commit on the same edge is not visible to that read.
- Address bits [1:0] are ignored. Index bits above log2(NUM_REGS) participate in the range check.
- Read and write channels are fully independent and may complete in the same cycle.
- Reset mid-transaction: pending AW/W and bvalid/rvalid drop immediately. No partial write is applied.

Optional Feature:
AXIL_REGFILE_PROT_EN
- Defined: awprot[0]/arprot[0] are sampled at handshake. Unprivileged (0) accesses get SLVERR: writes cause no change and no pulse; reads return rdata=0.
- Undefined: prot inputs are ignored; behaviour as above.

Decomposition:
Package axi_lite_regfile_pkg:
- RESP_OKAY=2'b00, RESP_SLVERR=2'b10
- function strb_merge(old, wdata, wstrb)
- function idx_legal(idx, num_regs)

Sub-module axi_lite_wr_ctrl: AW/W capture, hold flags, B generation; outputs commit, idx, data, strb.
Top level: register array, read path, pulses.

Test Plan:
- Write 0x12345678 to 0x00 with AW/W in the same cycle -> bvalid 1 cycle later, OKAY; regs_o[31:0]=0x12345678; wr_pulse_o=8'h01 for 1 cycle; read 0x00 returns 0x12345678 OKAY.
- W issued 3 cycles before AW, writing 0xAA55AA55 to 0x08 -> awready still high, bvalid 1 cycle after AW; readback 0xAA55AA55.
- Reg 2 holds 0xAA55AA55; write 0x11223344 with wstrb=4'b0101 -> reg 2 = 0xAA22AA44.
- regs_i slot 1 = 0xDEADBEEF; write 0x0BADC0DE to 0x04 -> SLVERR, no pulse. Then change regs_i to 0x00C0FFEE and read 0x04 -> 0x00C0FFEE OKAY.
- NUM_REGS=6: read 0x18 and write 0x1C -> rdata=0 and both responses SLVERR; no register changes.
- Hold bready/rready low 5 cycles -> bvalid/rvalid, bresp, rdata stay stable; awready/wready/arready low. Assert aresetn=0 mid-hold -> all valids drop asynchronously.
